// File: rtl/frv_asi_issue.sv
// frv_asi_issue: issues one ASI micro-op at a time, captures its result for writeback, and pulses AES flushes.
// The optional EXEC watchdog is enabled by defining FRV_ASI_WATCHDOG_EN.
module frv_asi_issue #(
  parameter int UOP_W       = 5,
  parameter int WDOG_CYCLES = 64
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [UOP_W-1:0] s_uop,
  input  logic [31:0]      s_rs1,
  input  logic [31:0]      s_rs2,
  input  logic [1:0]       s_shamt,
  input  logic [4:0]       s_rd,
  input  logic             pipe_kill,
  output logic             asi_valid,
  output logic [UOP_W-1:0] asi_uop,
  output logic [31:0]      asi_rs1,
  output logic [31:0]      asi_rs2,
  output logic [1:0]       asi_shamt,
  input  logic             asi_ready,
  input  logic [31:0]      asi_result,
  output logic             asi_flush_aessub,
  output logic             asi_flush_aesmix,
  output logic [31:0]      asi_flush_data,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [31:0]      d_result,
  output logic [4:0]       d_rd,
  output logic             d_err
);
  localparam logic [1:0] ASI_AES = 2'b01;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t state, n_state;
  logic [UOP_W-1:0] uop_q;
  logic [31:0] rs1_q, rs2_q, res_q;
  logic [1:0] shamt_q;
  logic [4:0] rd_q;
  logic flush_sub_q, flush_mix_q, in_exec, in_hold, accept, is_aes, abort, finish, timeout;
  if (WDOG_CYCLES < 2 || WDOG_CYCLES > 255) begin : g_wdog_range
    $error("WDOG_CYCLES must be within 2..255");
  end
  // Outputs are gated by reset so they read 0 while g_resetn is low, even before state clears.
  assign in_exec = g_resetn && state == EXEC;
  assign in_hold = g_resetn && state == HOLD;
  assign s_ready = g_resetn && !pipe_kill && (state == IDLE || (state == HOLD && d_ready));
  assign accept  = s_valid && s_ready;
  assign is_aes  = uop_q[UOP_W-1:UOP_W-2] == ASI_AES;
  assign abort   = in_exec && !asi_ready && (pipe_kill || timeout);
  assign finish  = in_exec && !pipe_kill && (asi_ready || timeout);
`ifdef FRV_ASI_WATCHDOG_EN
  localparam logic [7:0] WDOG_LIM = 8'(WDOG_CYCLES - 1);
  logic [7:0] cnt;
  logic err_q;
  assign timeout = in_exec && !asi_ready && !pipe_kill && cnt == WDOG_LIM;
  assign d_err   = in_hold && err_q;
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= accept ? 8'd0 : (in_exec && !asi_ready) ? cnt + 8'd1 : cnt;
      err_q <= finish ? timeout : err_q;
    end
  end
`else
  assign timeout = 1'b0;
  assign d_err   = 1'b0;
`endif
  always_comb begin
    n_state = state;
    case (state)
      IDLE:    n_state = accept ? EXEC : IDLE;
      EXEC:    n_state = pipe_kill ? IDLE : (asi_ready || timeout) ? HOLD : EXEC;
      HOLD:    n_state = pipe_kill ? IDLE : d_ready ? (s_valid ? EXEC : IDLE) : HOLD;
      default: n_state = IDLE;
    endcase
  end
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state       <= IDLE;
      uop_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      shamt_q     <= '0;
      rd_q        <= '0;
      res_q       <= '0;
      flush_sub_q <= 1'b0;
      flush_mix_q <= 1'b0;
    end else begin
      state       <= n_state;
      flush_sub_q <= abort && is_aes && !uop_q[2];
      flush_mix_q <= abort && is_aes && uop_q[2];
      if (accept) begin
        uop_q   <= s_uop;
        rs1_q   <= s_rs1;
        rs2_q   <= s_rs2;
        shamt_q <= s_shamt;
        rd_q    <= s_rd;
      end
      if (finish) res_q <= asi_ready ? asi_result : 32'd0;
    end
  end
  assign asi_valid        = in_exec;
  assign asi_uop          = in_exec ? uop_q : '0;
  assign asi_rs1          = in_exec ? rs1_q : '0;
  assign asi_rs2          = in_exec ? rs2_q : '0;
  assign asi_shamt        = in_exec ? shamt_q : '0;
  assign asi_flush_aessub = g_resetn && flush_sub_q;
  assign asi_flush_aesmix = g_resetn && flush_mix_q;
  assign asi_flush_data   = '0;
  assign d_valid          = in_hold;
  assign d_result         = in_hold ? res_q : '0;
  assign d_rd             = in_hold ? rd_q : '0;
endmodule

// File: tb/tb_frv_asi_issue.sv
// tb_frv_asi_issue: random traffic against a transaction-level reference of the ASI issue controller.
module tb_frv_asi_issue;
  localparam int WDOG = 4;
`ifdef FRV_ASI_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  logic g_clk = 1'b0, g_resetn = 1'b0;
  logic s_valid = 1'b0, s_ready, pipe_kill = 1'b0, asi_valid, asi_ready = 1'b0;
  logic [4:0] s_uop = '0, asi_uop, s_rd = '0, d_rd;
  logic [31:0] s_rs1 = '0, s_rs2 = '0, asi_rs1, asi_rs2, asi_result = '0, asi_flush_data, d_result;
  logic [1:0] s_shamt = '0, asi_shamt;
  logic asi_flush_aessub, asi_flush_aesmix, d_valid, d_ready = 1'b0, d_err;
  int n_chk = 0, n_err = 0, cyc = 0;
  typedef struct packed {
    logic [4:0]  uop;
    logic [31:0] rs1, rs2;
    logic [1:0]  shamt;
    logic [4:0]  rd;
  } op_t;
  op_t m_op;
  bit m_busy, m_pend, m_err, m_fsub, m_fmix, e_sready, acc, aes;
  int m_n, m_lat;
  logic [31:0] m_res;
  logic [4:0] m_rd;

  frv_asi_issue #(.UOP_W(5), .WDOG_CYCLES(WDOG)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .s_valid(s_valid), .s_ready(s_ready), .s_uop(s_uop),
    .s_rs1(s_rs1), .s_rs2(s_rs2), .s_shamt(s_shamt), .s_rd(s_rd), .pipe_kill(pipe_kill),
    .asi_valid(asi_valid), .asi_uop(asi_uop), .asi_rs1(asi_rs1), .asi_rs2(asi_rs2),
    .asi_shamt(asi_shamt), .asi_ready(asi_ready), .asi_result(asi_result),
    .asi_flush_aessub(asi_flush_aessub), .asi_flush_aesmix(asi_flush_aesmix),
    .asi_flush_data(asi_flush_data), .d_valid(d_valid), .d_ready(d_ready),
    .d_result(d_result), .d_rd(d_rd), .d_err(d_err)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d got %h exp %h", tag, cyc, got, exp);
    end
  endtask

  initial begin
    {m_busy, m_pend, m_err, m_fsub, m_fmix} = '0;
    m_op = '0; m_n = 0; m_lat = 1; m_res = '0; m_rd = '0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge g_clk);
      g_resetn   = !(cyc < 3 || (cyc >= 1500 && cyc < 1503));
      s_valid    = 1'($urandom_range(0, 1));
      s_uop      = 5'($urandom);
      s_rs1      = $urandom;
      s_rs2      = $urandom;
      s_shamt    = 2'($urandom);
      s_rd       = 5'($urandom);
      pipe_kill  = $urandom_range(0, 9) == 0;
      d_ready    = $urandom_range(0, 2) != 0;
      asi_ready  = m_busy ? (m_n + 1 == m_lat) : 1'($urandom_range(0, 1));
      asi_result = $urandom;
      #1;
      e_sready = g_resetn && !pipe_kill && !m_busy && (!m_pend || d_ready);
      chk("s_ready", 32'(s_ready), 32'(e_sready));
      chk("asi_valid", 32'(asi_valid), 32'(g_resetn && m_busy));
      chk("asi_uop", 32'(asi_uop), (g_resetn && m_busy) ? 32'(m_op.uop) : 32'd0);
      chk("asi_rs1", asi_rs1, (g_resetn && m_busy) ? m_op.rs1 : 32'd0);
      chk("asi_rs2", asi_rs2, (g_resetn && m_busy) ? m_op.rs2 : 32'd0);
      chk("asi_shamt", 32'(asi_shamt), (g_resetn && m_busy) ? 32'(m_op.shamt) : 32'd0);
      chk("flush_sub", 32'(asi_flush_aessub), 32'(g_resetn && m_fsub));
      chk("flush_mix", 32'(asi_flush_aesmix), 32'(g_resetn && m_fmix));
      chk("flush_data", asi_flush_data, 32'd0);
      chk("d_valid", 32'(d_valid), 32'(g_resetn && m_pend));
      chk("d_result", d_result, (g_resetn && m_pend) ? m_res : 32'd0);
      chk("d_rd", 32'(d_rd), (g_resetn && m_pend) ? 32'(m_rd) : 32'd0);
      chk("d_err", 32'(d_err), 32'(g_resetn && m_pend && m_err));
      // advance the reference by one clock using the inputs held over the coming edge
      if (!g_resetn) begin
        {m_busy, m_pend, m_err, m_fsub, m_fmix} = '0;
      end else begin
        acc = s_valid && e_sready;
        aes = m_op.uop[4:3] == 2'b01;
        m_fsub = 1'b0;
        m_fmix = 1'b0;
        if (m_busy) begin
          m_busy = 1'b0;
          if (pipe_kill) begin
            m_fsub = !asi_ready && aes && !m_op.uop[2];
            m_fmix = !asi_ready && aes && m_op.uop[2];
          end else if (asi_ready) begin
            m_pend = 1'b1; m_res = asi_result; m_err = 1'b0; m_rd = m_op.rd;
          end else if (WD_EN && m_n == WDOG - 1) begin
            m_pend = 1'b1; m_res = '0; m_err = 1'b1; m_rd = m_op.rd;
            m_fsub = aes && !m_op.uop[2];
            m_fmix = aes && m_op.uop[2];
          end else begin
            m_busy = 1'b1;
            m_n++;
          end
        end else begin
          if (m_pend && (pipe_kill || d_ready)) m_pend = 1'b0;
          if (acc) begin
            m_op   = '{uop: s_uop, rs1: s_rs1, rs2: s_rs2, shamt: s_shamt, rd: s_rd};
            m_busy = 1'b1;
            m_n    = 0;
            m_lat  = $urandom_range(1, 6);
          end
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
